// File: rtl/mem_bus_responder_if.sv
// -----------------------------------------------------------------------------
// mem_bus_responder_if
//
// Purpose : Valid/RW/ready handshake bus between the processor control unit
//           (master) and the word memory responder (slave).
//
// Signals : Valid  - request strobe, held high by the master until ready rises
//           RW     - 1 = read (fetch/load), 0 = write (store)
//           addr   - byte address
//           wdata  - store data
//           rdata  - read data, valid while ready=1 after a read completes
//           ready  - high = idle/complete, low = busy
//           err    - access fault flag (only when MEM_ALIGN_CHECK_EN is defined)
//
// Build macro: MEM_ALIGN_CHECK_EN adds the err signal to the bus.
// -----------------------------------------------------------------------------
interface mem_bus_responder_if;
    logic        Valid;
    logic        RW;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
`ifdef MEM_ALIGN_CHECK_EN
    logic        err;

    modport master (output Valid, RW, addr, wdata, input rdata, ready, err);
    modport slave  (input Valid, RW, addr, wdata, output rdata, ready, err);
`else
    modport master (output Valid, RW, addr, wdata, input rdata, ready);
    modport slave  (input Valid, RW, addr, wdata, output rdata, ready);
`endif
endinterface

// File: rtl/mem_bus_responder.sv
// -----------------------------------------------------------------------------
// mem_bus_responder
//
// Purpose : Single-port 32-bit word memory answering the control unit's
//           drop-then-raise ready handshake. A request seen in IDLE is latched
//           (RW, word index, wdata), ready drops for WAIT_CYCLES cycles, then
//           the access commits and ready rises again. A held Valid cannot
//           retrigger: the FSM parks in DONE until Valid is seen low.
//
// Ports   : clk   - single clock, rising edge
//           reset - synchronous active-low reset
//           bus   - mem_bus_responder_if.slave (Valid, RW, addr, wdata in;
//                   rdata, ready [, err] out)
//
// Params  : ADDR_WIDTH  - log2 of memory depth in words (default 10)
//           WAIT_CYCLES - busy cycles per access, 1..15 (default 2)
//
// Build macro: MEM_ALIGN_CHECK_EN - flags misaligned or out-of-range addresses
//           as faulted: the handshake still runs, writes are suppressed, reads
//           return 0 and err is raised from commit until the next acceptance.
//           Without it, addr[1:0] and bits above the word index are ignored.
// -----------------------------------------------------------------------------
module mem_bus_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    mem_bus_responder_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                  state_q,  state_d;
    logic [3:0]              cnt_q,    cnt_d;
    logic                    rw_q,     rw_d;
    logic [ADDR_WIDTH-1:0]   idx_q,    idx_d;
    logic [31:0]             wdata_q,  wdata_d;
    logic [31:0]             rdata_q,  rdata_d;
    logic                    ready_q,  ready_d;
    logic                    mem_we;

    logic [31:0]             mem [DEPTH];

`ifdef MEM_ALIGN_CHECK_EN
    logic                    fault_q,  fault_d;
    logic                    err_q,    err_d;
    logic                    addr_fault;

    // Misaligned byte address, or any bit set above the addressable range.
    assign addr_fault = (bus.addr[1:0] != 2'b00) ||
                        ((bus.addr >> (ADDR_WIDTH + 2)) != 32'd0);
`else
    // Without the check these address bits alias by design.
    logic                    unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[31:ADDR_WIDTH+2], bus.addr[1:0]};
`endif

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = ready_q;
        mem_we  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        fault_d = fault_q;
        err_d   = err_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.Valid) begin
                    rw_d    = bus.RW;
                    idx_d   = bus.addr[ADDR_WIDTH+1:2];
                    wdata_d = bus.wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    ready_d = 1'b0;
                    state_d = BUSY;
`ifdef MEM_ALIGN_CHECK_EN
                    fault_d = addr_fault;
                    err_d   = 1'b0;
`endif
                end
            end

            BUSY: begin
                // Counter was loaded with WAIT_CYCLES at acceptance, so the
                // commit edge where it reads 1 leaves ready low for exactly
                // WAIT_CYCLES cycles.
                if (cnt_q == 4'd1) begin
                    cnt_d   = 4'd0;
                    ready_d = 1'b1;
                    // Valid already dropped: skip DONE, nothing left to wait for.
                    state_d = bus.Valid ? DONE : IDLE;
`ifdef MEM_ALIGN_CHECK_EN
                    err_d   = fault_q;
                    if (rw_q) begin
                        rdata_d = fault_q ? 32'd0 : mem[idx_q];
                    end else begin
                        mem_we  = !fault_q;
                    end
`else
                    if (rw_q) begin
                        rdata_d = mem[idx_q];
                    end else begin
                        mem_we  = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            DONE: begin
                if (!bus.Valid) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the values from before this edge, independent of order.
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            fault_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            fault_q <= fault_d;
            err_q   <= err_d;
        end
    end

    assign bus.err = err_q;
`endif

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset so it maps onto plain RAM; only the write
    // enable is qualified by reset, which discards an access cut short by it.
    always_ff @(posedge clk) begin
        if (mem_we && reset) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_responder
//
// Directed bench for mem_bus_responder. Expected read data is pushed to a
// scoreboard queue from a reference word model when a read is issued and
// popped when ready rises. Build with +define+MEM_ALIGN_CHECK_EN to cover the
// fault path; the default build covers aliasing instead.
// -----------------------------------------------------------------------------
module tb_mem_bus_responder;

    localparam int AW = 10;
    localparam int WC = 2;

    localparam int M_NORMAL   = 0;
    localparam int M_SCRAMBLE = 1;
    localparam int M_DROP     = 2;
    localparam int M_HOLD     = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_bus_responder_if bus ();

    mem_bus_responder #(
        .ADDR_WIDTH  (AW),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    logic [31:0] model [int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) & ((32'd1 << AW) - 32'd1));
    endfunction

    // Sample point: 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full handshake. Inputs are applied away from the edge; the
    // reference model and scoreboard are updated as the request is issued.
    task automatic access(input logic rw, input logic [31:0] a, input logic [31:0] d,
                          input bit faulted, input int mode);
        int low;
        bus.Valid = 1'b1;
        bus.RW    = rw;
        bus.addr  = a;
        bus.wdata = d;
        if (rw) begin
            if (faulted) exp_q.push_back(32'd0);
            else         exp_q.push_back(model.exists(idx_of(a)) ? model[idx_of(a)] : 32'd0);
        end else if (!faulted) begin
            model[idx_of(a)] = d;
        end

        step();
        check("accept_ready_low", {31'd0, bus.ready}, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        check("accept_err_clear", {31'd0, bus.err}, 32'd0);
`endif
        low = 1;
        if (mode == M_SCRAMBLE) begin
            bus.addr  = a ^ 32'h4;
            bus.wdata = ~d;
            bus.RW    = ~rw;
        end
        if (mode == M_DROP) bus.Valid = 1'b0;

        for (int i = 0; i < 40 && bus.ready !== 1'b1; i++) begin
            step();
            if (bus.ready !== 1'b1) low++;
        end
        check("ready_rise", {31'd0, bus.ready}, 32'd1);
        check("ready_low_cycles", 32'(low), 32'(WC));

        if (rw) begin
            if (exp_q.size() > 0) check("rdata", bus.rdata, exp_q.pop_front());
            else                  check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
        end
`ifdef MEM_ALIGN_CHECK_EN
        check("err_at_commit", {31'd0, bus.err}, {31'd0, faulted});
`endif

        if (mode == M_HOLD) begin
            for (int i = 0; i < 3; i++) begin
                step();
                check("held_valid_no_retrigger", {31'd0, bus.ready}, 32'd1);
            end
        end

        if (mode != M_DROP) begin
            bus.Valid = 1'b0;
            step();
        end
    endtask

    initial begin
        reset     = 1'b0;
        bus.Valid = 1'b0;
        bus.RW    = 1'b1;
        bus.addr  = 32'd0;
        bus.wdata = 32'd0;

        // Reset for two cycles, then idle with Valid low.
        repeat (2) step();
        check("reset_ready", {31'd0, bus.ready}, 32'd1);
        check("reset_rdata", bus.rdata, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        check("reset_err", {31'd0, bus.err}, 32'd0);
`endif
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_ready", {31'd0, bus.ready}, 32'd1);
            check("idle_rdata", bus.rdata, 32'd0);
        end

        // Write with Valid held past completion, then read back.
        access(1'b0, 32'h10, 32'hDEADBEEF, 1'b0, M_HOLD);
        access(1'b1, 32'h10, 32'h0,        1'b0, M_NORMAL);

        // Inputs changed during BUSY must not affect the latched write.
        access(1'b0, 32'h24, 32'h11112222, 1'b0, M_NORMAL);
        access(1'b0, 32'h20, 32'h600DF00D, 1'b0, M_SCRAMBLE);
        access(1'b1, 32'h20, 32'h0,        1'b0, M_NORMAL);
        access(1'b1, 32'h24, 32'h0,        1'b0, M_NORMAL);

        // Write then read the same index back to back.
        access(1'b0, 32'h30, 32'hA1B2C3D4, 1'b0, M_NORMAL);
        access(1'b1, 32'h30, 32'h0,        1'b0, M_NORMAL);

        // Reset in the middle of a write: the write is discarded.
        access(1'b0, 32'h40, 32'hCAFEF00D, 1'b0, M_NORMAL);
        bus.Valid = 1'b1;
        bus.RW    = 1'b0;
        bus.addr  = 32'h40;
        bus.wdata = 32'h12345678;
        step();
        check("mid_reset_busy", {31'd0, bus.ready}, 32'd0);
        reset = 1'b0;
        step();
        check("mid_reset_ready", {31'd0, bus.ready}, 32'd1);
        check("mid_reset_rdata", bus.rdata, 32'd0);
        reset     = 1'b1;
        bus.Valid = 1'b0;
        step();
        access(1'b1, 32'h40, 32'h0, 1'b0, M_NORMAL);

        // Valid dropped during BUSY: access completes, next request accepted
        // on the edge right after ready rises.
        access(1'b1, 32'h10, 32'h0, 1'b0, M_DROP);
        access(1'b1, 32'h30, 32'h0, 1'b0, M_NORMAL);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned write is faulted and leaves memory untouched.
        access(1'b0, 32'h13,   32'h55555555, 1'b1, M_NORMAL);
        access(1'b1, 32'h10,   32'h0,        1'b0, M_NORMAL);
        // Out-of-range read returns 0 with err; next access clears err.
        access(1'b1, 32'h1000, 32'h0,        1'b1, M_NORMAL);
        access(1'b1, 32'h30,   32'h0,        1'b0, M_NORMAL);
`else
        // Upper address bits alias, low byte bits are ignored.
        access(1'b0, 32'h1010, 32'hA5A55A5A, 1'b0, M_NORMAL);
        access(1'b1, 32'h10,   32'h0,        1'b0, M_NORMAL);
        access(1'b1, 32'h13,   32'h0,        1'b0, M_NORMAL);
`endif

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
